int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 142 ++++++++++++++
 tb/tb_int_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Six-source interrupt controller: IRQ synchronizers, edge/level pending,
// fixed priority with single-level in-service tracking, CP0 HWINT vector.
module int_ctrl #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [5:0] RESET_ENABLE = 6'h00
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    input  logic [5:0]  IRQ,
    input  logic        IntAck,
    output logic [5:0]  HWINT,
    output logic [2:0]  IntID
);

    typedef enum logic {IDLE, SERVICE} state_t;

    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [5:0] s, s_d_q, rise;
    logic [5:0] en_q, mode_q, pend_q, pend_d;
    logic [5:0] hwint_q, above, eligible;
    logic [2:0] serv_q, serv_d, id;
    state_t     state_q, state_d;
    logic       wr_en, wr_mode, wr_pend, eoi;
    logic       ack_take, inservice;

    assign wr_en   = WE && (Addr == 2'd0);
    assign wr_mode = WE && (Addr == 2'd1);
    assign wr_pend = WE && (Addr == 2'd2);
    assign eoi     = WE && (Addr == 2'd3);

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '0;
            s_d_q  <= '0;
        end else begin
            sync_q[0] <= IRQ;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
            s_d_q <= s;
        end
    end

    // Only sources strictly above the one in service may preempt the line.
    always_comb begin
        above = '0;
        for (int i = 0; i < 6; i++)
            above[i] = (3'(i) > serv_q);
    end

    assign eligible = (state_q == SERVICE) ? (pend_q & en_q & above)
                                           : (pend_q & en_q);

    always_comb begin
        id = 3'd7;
        for (int i = 0; i < 6; i++)
            if (eligible[i]) id = 3'(i);
    end

    assign IntID = id;

    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < 6; i++) begin
            if (mode_q[i]) begin
                if (ack_take && (id == 3'(i))) pend_d[i] = 1'b0;
                if (wr_pend && WData[i])       pend_d[i] = 1'b0;
                if (rise[i])                   pend_d[i] = 1'b1;
            end else begin
                pend_d[i] = s[i];
            end
            if (wr_mode && (WData[i] != mode_q[i])) pend_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            en_q    <= RESET_ENABLE;
            mode_q  <= '0;
            pend_q  <= '0;
            hwint_q <= '0;
        end else begin
            if (wr_en)   en_q   <= WData[5:0];
            if (wr_mode) mode_q <= WData[5:0];
            pend_q  <= pend_d;
            hwint_q <= eligible;
        end
    end

    assign HWINT = hwint_q;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            serv_q  <= '0;
        end else begin
            state_q <= state_d;
            serv_q  <= serv_d;
        end
    end

    // EOI outranks a simultaneous IntAck; there is no nesting.
    always_comb begin
        state_d = state_q;
        serv_d  = serv_q;
        unique case (state_q)
            IDLE: begin
                if (IntAck && (id != 3'd7)) begin
                    state_d = SERVICE;
                    serv_d  = id;
                end
            end
            SERVICE: begin
                if (eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inservice = (state_q == SERVICE);
        ack_take  = (state_q == IDLE) && IntAck && (id != 3'd7);
    end

    always_comb begin
        RData = '0;
        unique case (Addr)
            2'd0: RData[5:0] = en_q;
            2'd1: RData[5:0] = mode_q;
            2'd2: RData[5:0] = pend_q;
            2'd3: RData = {23'b0, inservice, 1'b0, serv_q, 1'b0, id};
            default: RData = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: latency, edge/level pending, service FSM,
// EOI, software clears and asynchronous reset.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] WData;
    logic [31:0] RData;
    logic [5:0]  IRQ;
    logic        IntAck;
    logic [5:0]  HWINT;
    logic [2:0]  IntID;

    int tests  = 0;
    int failed = 0;

    int_ctrl #(.SYNC_STAGES(2), .RESET_ENABLE(6'h00)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .Addr    (Addr),
        .WE      (WE),
        .WData   (WData),
        .RData   (RData),
        .IRQ     (IRQ),
        .IntAck  (IntAck),
        .HWINT   (HWINT),
        .IntID   (IntID)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr  = a;
        WData = d;
        WE    = 1'b1;
        tick();
        WE    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag,
                      input logic [31:0] exp);
        Addr = a;
        #1;
        chk(tag, RData, exp);
    endtask

    task automatic ack();
        IntAck = 1'b1;
        tick();
        IntAck = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0;
        Addr    = '0;
        WE      = 1'b0;
        WData   = '0;
        IRQ     = '0;
        IntAck  = 1'b0;
        #2;
        chk("rst_hwint", 32'(HWINT), 32'h0);
        chk("rst_intid", 32'(IntID), 32'h7);
        rd(2'd0, "rst_enable", 32'h0);
        rd(2'd3, "rst_status", 32'h007);
        #7 Reset_n = 1'b1;
        tick();

        wr(2'd0, 32'h3F);
        wr(2'd1, 32'h04);
        rd(2'd0, "enable_rd", 32'h3F);
        rd(2'd1, "mode_rd", 32'h04);

        // one-cycle pulse on edge source 2
        IRQ = 6'h04;
        tick();
        IRQ = 6'h00;
        tick();
        tick();
        chk("lat_e3_hwint", 32'(HWINT), 32'h00);
        chk("lat_e3_intid", 32'(IntID), 32'h2);
        tick();
        chk("lat_e4_hwint", 32'(HWINT), 32'h04);
        tick();
        tick();
        rd(2'd2, "edge_hold", 32'h04);

        ack();
        rd(2'd3, "ack_status", 32'h127);
        rd(2'd2, "ack_clr_pend", 32'h00);
        tick();
        chk("svc_hwint0", 32'(HWINT), 32'h00);

        IRQ = 6'h02;
        repeat (4) tick();
        chk("svc_low_masked", 32'(HWINT), 32'h00);
        rd(2'd2, "level_pend", 32'h02);

        IRQ = 6'h22;
        repeat (4) tick();
        chk("svc_high_hwint", 32'(HWINT), 32'h20);
        chk("svc_high_id", 32'(IntID), 32'h5);

        wr(2'd3, 32'h0);
        rd(2'd3, "eoi_status", 32'h025);
        tick();
        chk("eoi_hwint", 32'(HWINT), 32'h22);

        // software clear racing a new rise on edge source 0
        wr(2'd1, 32'h05);
        IRQ = 6'h23;
        tick();
        tick();
        wr(2'd2, 32'h01);
        rd(2'd2, "rise_wins", 32'h23);
        wr(2'd2, 32'h01);
        rd(2'd2, "sw_clear", 32'h22);
        wr(2'd2, 32'h22);
        rd(2'd2, "level_noclr", 32'h22);

        // mode change clears the affected pending bit
        wr(2'd1, 32'h25);
        rd(2'd2, "mode_clr", 32'h02);
        tick();
        rd(2'd2, "mode_clr_hold", 32'h02);
        wr(2'd1, 32'h05);
        rd(2'd2, "mode_back_clr", 32'h02);
        tick();
        rd(2'd2, "mode_back_lvl", 32'h22);
        chk("idle_id5", 32'(IntID), 32'h5);

        ack();
        rd(2'd3, "svc5_status", 32'h157);
        wr(2'd0, 32'h1F);
        rd(2'd3, "en_clr_keeps", 32'h157);
        wr(2'd0, 32'h3F);
        IntAck = 1'b1;
        wr(2'd3, 32'h0);
        IntAck = 1'b0;
        rd(2'd3, "eoi_ack_same", 32'h055);
        wr(2'd0, 32'h00);
        rd(2'd3, "none_elig", 32'h057);
        ack();
        rd(2'd3, "ack_id7_noop", 32'h057);

        wr(2'd0, 32'h3F);
        tick();
        chk("pre_hwint", 32'(HWINT), 32'h22);
        ack();
        rd(2'd3, "pre_rst_svc", 32'h157);
        chk("pre_rst_hwint", 32'(HWINT), 32'h22);

        #2 Reset_n = 1'b0;
        #1;
        chk("arst_hwint", 32'(HWINT), 32'h00);
        rd(2'd3, "arst_status", 32'h007);
        rd(2'd0, "arst_enable", 32'h00);
        rd(2'd2, "arst_pend", 32'h00);
        rd(2'd1, "arst_mode", 32'h00);
        #3 Reset_n = 1'b1;
        tick();
        chk("post_rst_hwint", 32'(HWINT), 32'h00);
        rd(2'd3, "post_rst_status", 32'h007);
        IRQ = 6'h00;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
